// File: rtl/ixu_bundle_decode_if.sv
// rtl/ixu_bundle_decode_if.sv - input/output bundle bus of the IXU bundle decode stage
interface ixu_bundle_decode_if #(
  parameter int LANES = 2,
  parameter int XLEN  = 32,
  parameter int OPW   = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*32-1:0]   in_inst;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*OPW-1:0]  out_op;
  logic [LANES*5-1:0]    out_rd;
  logic [LANES*5-1:0]    out_rs1;
  logic [LANES*5-1:0]    out_rs2;
  logic [LANES*XLEN-1:0] out_imm;
  logic [LANES-1:0]      out_is_imm;
  logic [LANES-1:0]      out_is_nop;
  logic [LANES-1:0]      out_illegal;
  logic                  out_any_illegal;

  // Surrounding pipeline: supplies bundles and consumes decoded results
  modport master (
    output in_valid, in_inst, out_ready,
    input  in_ready, out_valid, out_op, out_rd, out_rs1, out_rs2, out_imm,
           out_is_imm, out_is_nop, out_illegal, out_any_illegal
  );

  // Decode stage
  modport slave (
    input  in_valid, in_inst, out_ready,
    output in_ready, out_valid, out_op, out_rd, out_rs1, out_rs2, out_imm,
           out_is_imm, out_is_nop, out_illegal, out_any_illegal
  );
endinterface

// File: rtl/ixu_bundle_decode.sv
// rtl/ixu_bundle_decode.sv - registered multi-lane RV32I ALU decode with 2-entry skid (option: IXU_DEC_PERF_EN)
module ixu_bundle_decode #(
  parameter int LANES = 2,
  parameter int XLEN  = 32,
  parameter int OPW   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  ixu_bundle_decode_if.slave bus
`ifdef IXU_DEC_PERF_EN
  ,
  output logic [31:0]       perf_bundles,
  output logic [31:0]       perf_nops,
  output logic [31:0]       perf_illegal
`endif
);

  localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(2);
  localparam logic [OPW-1:0] OP_OR   = OPW'(3);
  localparam logic [OPW-1:0] OP_AND  = OPW'(4);
  localparam logic [OPW-1:0] OP_SLL  = OPW'(5);
  localparam logic [OPW-1:0] OP_SRL  = OPW'(6);
  localparam logic [OPW-1:0] OP_SRA  = OPW'(7);
  localparam logic [OPW-1:0] OP_SLT  = OPW'(8);
  localparam logic [OPW-1:0] OP_SLTU = OPW'(9);
  localparam logic [OPW-1:0] OP_INV  = {OPW{1'b1}};

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  typedef struct packed {
    logic [OPW-1:0]  op;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            is_imm;
    logic            is_nop;
    logic            illegal;
  } lane_t;

  // Single-lane decode; starts from "illegal, raw fields" and clears illegal on a recognised encoding
  function automatic lane_t decode_lane(input logic [31:0] inst);
    lane_t      l;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc       = inst[6:0];
    f3        = inst[14:12];
    f7        = inst[31:25];
    l.op      = OP_INV;
    l.rd      = inst[11:7];
    l.rs1     = inst[19:15];
    l.rs2     = inst[24:20];
    l.imm     = '0;
    l.is_imm  = 1'b0;
    l.is_nop  = 1'b0;
    l.illegal = 1'b1;
    if (inst == 32'h0000_0000 || inst == 32'h0000_0013) begin
      l        = '0;
      l.is_nop = 1'b1;
    end else if (opc == OPC_R) begin
      if (f7 == 7'h00) begin
        l.illegal = 1'b0;
        case (f3)
          3'd0:    l.op = OP_ADD;
          3'd1:    l.op = OP_SLL;
          3'd2:    l.op = OP_SLT;
          3'd3:    l.op = OP_SLTU;
          3'd4:    l.op = OP_XOR;
          3'd5:    l.op = OP_SRL;
          3'd6:    l.op = OP_OR;
          default: l.op = OP_AND;
        endcase
      end else if (f7 == 7'h20 && f3 == 3'd0) begin
        l.illegal = 1'b0;
        l.op      = OP_SUB;
      end else if (f7 == 7'h20 && f3 == 3'd5) begin
        l.illegal = 1'b0;
        l.op      = OP_SRA;
      end
    end else if (opc == OPC_I) begin
      l.is_imm  = 1'b1;
      l.rs2     = '0;
      l.imm     = {{(XLEN-12){inst[31]}}, inst[31:20]};
      l.illegal = 1'b0;
      case (f3)
        3'd0: l.op = OP_ADD;
        3'd1: begin
          if (f7 == 7'h00) l.op = OP_SLL;
          else             l.illegal = 1'b1;
        end
        3'd2: l.op = OP_SLT;
        3'd3: l.op = OP_SLTU;
        3'd4: l.op = OP_XOR;
        3'd5: begin
          if (f7 == 7'h00)      l.op = OP_SRL;
          else if (f7 == 7'h20) l.op = OP_SRA;
          else                  l.illegal = 1'b1;
        end
        3'd6:    l.op = OP_OR;
        default: l.op = OP_AND;
      endcase
      if (l.illegal) l.op = OP_INV;
    end
    return l;
  endfunction

  lane_t [LANES-1:0] dec;
  logic              dec_any_ill;
  lane_t [LANES-1:0] out_q, out_d, skid_q, skid_d;
  logic              out_valid_q, out_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              out_any_q, out_any_d;
  logic              skid_any_q, skid_any_d;
  logic              accept, xfer;

  // Decode every lane of the incoming bundle
  always_comb begin
    dec_any_ill = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      dec[i]      = decode_lane(bus.in_inst[32*i +: 32]);
      dec_any_ill = dec_any_ill | dec[i].illegal;
    end
  end

  assign accept = bus.in_valid && in_ready_q && !flush;
  assign xfer   = out_valid_q && bus.out_ready;

  // Next state of output register and skid; flush wins over accept/refill
  always_comb begin
    out_d        = out_q;
    out_any_d    = out_any_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_any_d   = skid_any_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || xfer) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_any_d    = skid_any_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec;
        out_any_d   = dec_any_ill;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_any_d   = dec_any_ill;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  // Stage registers; reset discards anything held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      out_any_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_any_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      out_any_q    <= out_any_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_any_q   <= skid_any_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  logic [LANES*OPW-1:0]  op_flat;
  logic [LANES*5-1:0]    rd_flat, rs1_flat, rs2_flat;
  logic [LANES*XLEN-1:0] imm_flat;
  logic [LANES-1:0]      is_imm_flat, is_nop_flat, illegal_flat;

  // Flatten the held bundle onto the lane-packed output buses
  always_comb begin
    op_flat      = '0;
    rd_flat      = '0;
    rs1_flat     = '0;
    rs2_flat     = '0;
    imm_flat     = '0;
    is_imm_flat  = '0;
    is_nop_flat  = '0;
    illegal_flat = '0;
    for (int i = 0; i < LANES; i++) begin
      op_flat[i*OPW +: OPW]    = out_q[i].op;
      rd_flat[i*5 +: 5]        = out_q[i].rd;
      rs1_flat[i*5 +: 5]       = out_q[i].rs1;
      rs2_flat[i*5 +: 5]       = out_q[i].rs2;
      imm_flat[i*XLEN +: XLEN] = out_q[i].imm;
      is_imm_flat[i]           = out_q[i].is_imm;
      is_nop_flat[i]           = out_q[i].is_nop;
      illegal_flat[i]          = out_q[i].illegal;
    end
  end

  assign bus.in_ready        = in_ready_q;
  assign bus.out_valid       = out_valid_q;
  assign bus.out_op          = op_flat;
  assign bus.out_rd          = rd_flat;
  assign bus.out_rs1         = rs1_flat;
  assign bus.out_rs2         = rs2_flat;
  assign bus.out_imm         = imm_flat;
  assign bus.out_is_imm      = is_imm_flat;
  assign bus.out_is_nop      = is_nop_flat;
  assign bus.out_illegal     = illegal_flat;
  assign bus.out_any_illegal = out_any_q;

`ifdef IXU_DEC_PERF_EN
  logic [31:0] nop_cnt, ill_cnt;
  logic [31:0] perf_bundles_q, perf_nops_q, perf_illegal_q;

  // Per-bundle NOP and illegal lane counts of the bundle currently on the output
  always_comb begin
    nop_cnt = '0;
    ill_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      nop_cnt = nop_cnt + 32'(out_q[i].is_nop);
      ill_cnt = ill_cnt + 32'(out_q[i].illegal);
    end
  end

  // Event counters advance on every output transfer, flush cycle included
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bundles_q <= '0;
      perf_nops_q    <= '0;
      perf_illegal_q <= '0;
    end else if (xfer) begin
      perf_bundles_q <= perf_bundles_q + 32'd1;
      perf_nops_q    <= perf_nops_q + nop_cnt;
      perf_illegal_q <= perf_illegal_q + ill_cnt;
    end
  end

  assign perf_bundles = perf_bundles_q;
  assign perf_nops    = perf_nops_q;
  assign perf_illegal = perf_illegal_q;
`endif

endmodule

// File: tb/tb_ixu_bundle_decode.sv
// tb/tb_ixu_bundle_decode.sv - self-checking bench for ixu_bundle_decode
module tb_ixu_bundle_decode;
  localparam int LANES = 2;
  localparam int XLEN  = 32;
  localparam int OPW   = 4;

  localparam int RTAB[8] = '{0, 5, 8, 9, 2, 6, 3, 4};
  localparam int ITAB[8] = '{0, -1, 8, 9, 2, -1, 3, 4};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   xfer_cnt = 0;

  always #5 clk = ~clk;

  ixu_bundle_decode_if #(.LANES(LANES), .XLEN(XLEN), .OPW(OPW)) bus ();

`ifdef IXU_DEC_PERF_EN
  logic [31:0] perf_bundles, perf_nops, perf_illegal;
`endif

  ixu_bundle_decode #(.LANES(LANES), .XLEN(XLEN), .OPW(OPW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
`ifdef IXU_DEC_PERF_EN
    ,
    .perf_bundles (perf_bundles),
    .perf_nops    (perf_nops),
    .perf_illegal (perf_illegal)
`endif
  );

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        is_imm;
    logic        is_nop;
    logic        illegal;
  } exp_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model_lane(input logic [31:0] w);
    exp_t e;
    int   code;
    e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
    e.imm = 32'd0; e.is_imm = 1'b0; e.is_nop = 1'b0;
    code = -1;
    if (w == 32'h0 || w == 32'h13) begin
      e.rd = 5'd0; e.rs1 = 5'd0; e.rs2 = 5'd0; e.is_nop = 1'b1; code = 0;
    end else if (w[6:0] == 7'h33) begin
      if (w[31:25] == 7'h00) code = RTAB[w[14:12]];
      else if (w[31:25] == 7'h20 && w[14:12] == 3'd0) code = 1;
      else if (w[31:25] == 7'h20 && w[14:12] == 3'd5) code = 7;
    end else if (w[6:0] == 7'h13) begin
      e.is_imm = 1'b1;
      e.rs2    = 5'd0;
      e.imm    = 32'(int'(w[31:20]) - (w[31] ? 4096 : 0));
      if (w[14:12] == 3'd1) code = (w[31:25] == 7'h00) ? 5 : -1;
      else if (w[14:12] == 3'd5) code = (w[31:25] == 7'h00) ? 6 : ((w[31:25] == 7'h20) ? 7 : -1);
      else code = ITAB[w[14:12]];
    end
    e.illegal = (code < 0);
    e.op      = (code < 0) ? 4'hF : 4'(code);
    return e;
  endfunction

  // Reference: a 2-deep FIFO of raw bundles; head is what must be on the output
  logic [63:0] mq[$];
  logic [31:0] m_bundles = 0, m_nops = 0, m_ill = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_bundles = 0; m_nops = 0; m_ill = 0;
    end else begin
      bit do_x, do_a;
      do_x = (mq.size() > 0) && bus.out_ready;
      do_a = bus.in_valid && (mq.size() < 2) && !flush;
      if (do_x) begin
        m_bundles = m_bundles + 1;
        for (int i = 0; i < LANES; i++) begin
          exp_t e;
          e = model_lane(mq[0][32*i +: 32]);
          m_nops = m_nops + 32'(e.is_nop);
          m_ill  = m_ill + 32'(e.illegal);
        end
      end
      if (flush) mq.delete();
      else begin
        if (do_x) void'(mq.pop_front());
        if (do_a) mq.push_back(bus.in_inst);
      end
    end
  end

  always @(posedge clk)
    if (rst_n && bus.out_valid && bus.out_ready) xfer_cnt++;

  // Every mid-cycle: handshake state and head-of-FIFO contents must match
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
      chk("in_ready", 64'(bus.in_ready), 64'(mq.size() < 2));
      if (mq.size() > 0) begin
        logic any;
        any = 1'b0;
        for (int i = 0; i < LANES; i++) begin
          exp_t e;
          e = model_lane(mq[0][32*i +: 32]);
          any = any | e.illegal;
          chk($sformatf("op[%0d]", i), 64'(bus.out_op[OPW*i +: OPW]), 64'(e.op));
          chk($sformatf("rd[%0d]", i), 64'(bus.out_rd[5*i +: 5]), 64'(e.rd));
          chk($sformatf("rs1[%0d]", i), 64'(bus.out_rs1[5*i +: 5]), 64'(e.rs1));
          chk($sformatf("rs2[%0d]", i), 64'(bus.out_rs2[5*i +: 5]), 64'(e.rs2));
          chk($sformatf("imm[%0d]", i), 64'(bus.out_imm[XLEN*i +: XLEN]), 64'(e.imm));
          chk($sformatf("is_imm[%0d]", i), 64'(bus.out_is_imm[i]), 64'(e.is_imm));
          chk($sformatf("is_nop[%0d]", i), 64'(bus.out_is_nop[i]), 64'(e.is_nop));
          chk($sformatf("illegal[%0d]", i), 64'(bus.out_illegal[i]), 64'(e.illegal));
        end
        chk("any_illegal", 64'(bus.out_any_illegal), 64'(any));
      end
`ifdef IXU_DEC_PERF_EN
      chk("perf_bundles", 64'(perf_bundles), 64'(m_bundles));
      chk("perf_nops", 64'(perf_nops), 64'(m_nops));
      chk("perf_illegal", 64'(perf_illegal), 64'(m_ill));
`endif
    end
  end

  // Present one bundle and hold it until accepted (bounded); returns just after the accepting edge
  task automatic send(input logic [63:0] b);
    bit rdy;
    rdy = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_inst  = b;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
    end
    if (!rdy) chk("send_timeout", 64'd0, 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] vec[28] = '{
    32'h003100B3, 32'h003110B3, 32'h003120B3, 32'h003130B3,
    32'h003140B3, 32'h003150B3, 32'h003160B3, 32'h003170B3,
    32'h403150B3, 32'h403100B3, 32'h403110B3, 32'h023100B3,
    32'h80010093, 32'h7FF12093, 32'h00113093, 32'hFFF14093,
    32'h12316093, 32'h0FF17093, 32'h00511093, 32'h40511093,
    32'h00515093, 32'h40515093, 32'h20515093, 32'h00100013,
    32'h123450B7, 32'hFFFFFFFF, 32'h00000013, 32'h00000000
  };

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_inst   = '0;
    bus.out_ready = 1'b1;

    idle(3);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_op", 64'(bus.out_op), 64'd0);
    chk("rst_imm", 64'(bus.out_imm), 64'd0);
    chk("rst_any_ill", 64'(bus.out_any_illegal), 64'd0);
    rst_n = 1'b1;
    idle(1);

    // Test 1: R-type ADD (lane0) and SUB (lane1)
    send({32'h407302B3, 32'h002081B3});
    chk("t1_op", 64'(bus.out_op), 64'h10);
    chk("t1_rd", 64'(bus.out_rd), 64'({5'd5, 5'd3}));
    chk("t1_rs1", 64'(bus.out_rs1), 64'({5'd6, 5'd1}));
    chk("t1_rs2", 64'(bus.out_rs2), 64'({5'd7, 5'd2}));
    chk("t1_is_imm", 64'(bus.out_is_imm), 64'd0);
    chk("t1_illegal", 64'(bus.out_illegal), 64'd0);

    // Test 2: ADDI -1 (lane0), SRAI (lane1)
    send({32'h40315113, 32'hFFF00093});
    chk("t2_op", 64'(bus.out_op), 64'h70);
    chk("t2_rd", 64'(bus.out_rd), 64'({5'd2, 5'd1}));
    chk("t2_rs1_l1", 64'(bus.out_rs1[9:5]), 64'd2);
    chk("t2_imm", 64'(bus.out_imm), 64'h00000403_FFFFFFFF);
    chk("t2_is_imm", 64'(bus.out_is_imm), 64'd3);

    // Test 3: NOP (lane0), load opcode illegal (lane1)
    send({32'h00002003, 32'h00000000});
    chk("t3_nop", 64'(bus.out_is_nop), 64'd1);
    chk("t3_illegal", 64'(bus.out_illegal), 64'd2);
    chk("t3_op", 64'(bus.out_op), 64'hF0);
    chk("t3_any", 64'(bus.out_any_illegal), 64'd1);
    chk("t3_in_ready", 64'(bus.in_ready), 64'd1);
    idle(2);

    // Decode table sweep with intermittent backpressure
    for (int k = 0; k < 14; k++) begin
      bus.out_ready = (k % 3 != 1);
      send({vec[2*k+1], vec[2*k]});
    end
    bus.out_ready = 1'b1;
    idle(4);

    // Test 4: stall with A on output, B in skid, C waiting
    xfer_cnt = 0;
    bus.out_ready = 1'b0;
    send({32'h003100B3, 32'h403100B3});
    send({32'h00515093, 32'hFFF14093});
    chk("t4_in_ready_full", 64'(bus.in_ready), 64'd0);
    chk("t4_hold_op", 64'(bus.out_op), 64'h01);
    bus.in_valid = 1'b1;
    bus.in_inst  = {32'h00000013, 32'h003170B3};
    idle(3);
    chk("t4_still_full", 64'(bus.in_ready), 64'd0);
    chk("t4_hold_op2", 64'(bus.out_op), 64'h01);
    bus.out_ready = 1'b1;
    send({32'h00000013, 32'h003170B3});
    idle(4);
    chk("t4_xfers", 64'(xfer_cnt), 64'd3);

    // Test 5: flush with output and skid full plus an incoming bundle
    bus.out_ready = 1'b0;
    send({32'h003140B3, 32'h003150B3});
    send({32'h00113093, 32'h7FF12093});
    bus.in_valid = 1'b1;
    bus.in_inst  = {32'h0FF17093, 32'h12316093};
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("t5_out_valid", 64'(bus.out_valid), 64'd0);
    chk("t5_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    idle(4);

    // Flush coinciding with an output transfer
    send({32'h023100B3, 32'h003120B3});
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    chk("t5b_out_valid", 64'(bus.out_valid), 64'd0);
    idle(2);

    // Reset while holding two bundles
    bus.out_ready = 1'b0;
    send({32'h003100B3, 32'h003110B3});
    send({32'h003120B3, 32'h003130B3});
    rst_n = 1'b0;
    #1;
    chk("rstmid_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rstmid_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rstmid_op", 64'(bus.out_op), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    idle(2);

`ifdef IXU_DEC_PERF_EN
    // Test 6: counters over 3 bundles with 2 NOPs and 1 illegal, then flush
    chk("t6_rst_bundles", 64'(perf_bundles), 64'd0);
    send({32'h002081B3, 32'h00000013});
    send({32'h002081B3, 32'h00000000});
    send({32'h00002003, 32'h002081B3});
    idle(3);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    idle(1);
    chk("t6_bundles", 64'(perf_bundles), 64'd3);
    chk("t6_nops", 64'(perf_nops), 64'd2);
    chk("t6_illegal", 64'(perf_illegal), 64'd1);
`endif

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
